// File: rtl/t_skew_pkg.sv
// Shared definitions for the skew sensor and its measurement controller.
//   STAGES_DEF      default delay-chain length of the sensor
//   LOG2_N_MAX_DEF  default largest block-size exponent
//   skew_w()        binary skew-code width for a given chain length
//   t_skew_state_e  measurement controller states
//   t_skew_res_s    result payload as seen by the register block
package t_skew_pkg;

    localparam int unsigned STAGES_DEF     = 64;
    localparam int unsigned LOG2_N_MAX_DEF = 8;

    // Code must represent 0..stages inclusive.
    function automatic int unsigned skew_w(input int unsigned stages);
        return $clog2(stages + 1);
    endfunction

    localparam int unsigned CW_DEF = skew_w(STAGES_DEF);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        ACCUM,
        DONE
    } t_skew_state_e;

    typedef struct packed {
        logic [CW_DEF-1:0]                min;
        logic [CW_DEF-1:0]                max;
        logic [CW_DEF+LOG2_N_MAX_DEF-1:0] sum;
        logic [CW_DEF-1:0]                avg;
    } t_skew_res_s;

endpackage

// File: rtl/t_skew_median3.sv
// Three-tap running median of the raw skew code.
//   clk_b   in  sample clock
//   rst_n   in  synchronous active-low reset, clears both taps
//   din     in  raw skew code, shifted in every cycle
//   dout_c  out median(x[k-2], x[k-1], x[k]), combinational
module t_skew_median3 #(
    parameter int unsigned W = 7
) (
    input  logic         clk_b,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout_c
);

    logic [W-1:0] x1_q, x1_d;
    logic [W-1:0] x2_q, x2_d;
    logic [W-1:0] lo_c, hi_c, mid_c;

    // Two-deep tap line.
    always_ff @(posedge clk_b) begin
        if (!rst_n) begin
            x1_q <= '0;
            x2_q <= '0;
        end else begin
            x1_q <= x1_d;
            x2_q <= x2_d;
        end
    end

    // median = max(min(a,b), min(max(a,b), c))
    always_comb begin
        x1_d   = din;
        x2_d   = x1_q;
        lo_c   = (x2_q < x1_q) ? x2_q : x1_q;
        hi_c   = (x2_q < x1_q) ? x1_q : x2_q;
        mid_c  = (hi_c < din) ? hi_c : din;
        dout_c = (lo_c < mid_c) ? mid_c : lo_c;
    end

endmodule

// File: rtl/t_skew_meas_ctrl.sv
// Skew measurement controller: discards settle samples after start, then
// accumulates 2^n skew codes and reports min/max/sum/mean through a
// valid/ready result handshake.
//   clk_b, rst_n          clock, synchronous active-low reset
//   start, log2_n         begin a block (IDLE only), block-size exponent
//   skew_code             binary code from the sensor, every cycle
//   busy                  high in SETTLE and ACCUM
//   res_valid, res_ready  result handshake
//   res_min/max/sum/avg   block statistics, held until the next block ends
// Build option: SKEW_MEDIAN3_EN inserts a 3-tap median filter ahead of the
// accumulator and lengthens SETTLE by two cycles to prime it.
module t_skew_meas_ctrl
    import t_skew_pkg::*;
#(
    parameter  int unsigned STAGES     = STAGES_DEF,
    parameter  int unsigned LOG2_N_MAX = LOG2_N_MAX_DEF,
    parameter  int unsigned DISCARD    = 2,
    localparam int unsigned CW         = skew_w(STAGES),
    localparam int unsigned SW         = CW + LOG2_N_MAX
) (
    input  logic          clk_b,
    input  logic          rst_n,
    input  logic          start,
    input  logic [3:0]    log2_n,
    input  logic [CW-1:0] skew_code,
    output logic          busy,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [CW-1:0] res_min,
    output logic [CW-1:0] res_max,
    output logic [SW-1:0] res_sum,
    output logic [CW-1:0] res_avg
);

`ifdef SKEW_MEDIAN3_EN
    localparam int unsigned SETTLE_LEN = DISCARD + 2;
`else
    localparam int unsigned SETTLE_LEN = DISCARD;
`endif
    localparam int unsigned NW  = (LOG2_N_MAX > 0) ? LOG2_N_MAX : 1;
    localparam int unsigned SCW = (SETTLE_LEN > 1) ? $clog2(SETTLE_LEN) : 1;

    t_skew_state_e state_q, state_d;
    logic [3:0]    n_q, n_d;
    logic [NW-1:0] cnt_q, cnt_d;
    logic [SCW-1:0] set_q, set_d;
    logic [CW-1:0] acc_min_q, acc_min_d, acc_max_q, acc_max_d;
    logic [SW-1:0] acc_sum_q, acc_sum_d;
    logic [CW-1:0] res_min_q, res_min_d, res_max_q, res_max_d, res_avg_q, res_avg_d;
    logic [SW-1:0] res_sum_q, res_sum_d;
    logic          busy_q, busy_d, res_valid_q, res_valid_d;

    logic [CW-1:0] code_c;
    logic [CW-1:0] smp_min_c, smp_max_c;
    logic [SW-1:0] smp_sum_c;
    logic          first_c, last_c;

`ifdef SKEW_MEDIAN3_EN
    t_skew_median3 #(.W(CW)) u_median3 (
        .clk_b  (clk_b),
        .rst_n  (rst_n),
        .din    (skew_code),
        .dout_c (code_c)
    );
`else
    assign code_c = skew_code;
`endif

    // State and result registers.
    always_ff @(posedge clk_b) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            n_q         <= '0;
            cnt_q       <= '0;
            set_q       <= '0;
            acc_min_q   <= '0;
            acc_max_q   <= '0;
            acc_sum_q   <= '0;
            res_min_q   <= '0;
            res_max_q   <= '0;
            res_sum_q   <= '0;
            res_avg_q   <= '0;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            cnt_q       <= cnt_d;
            set_q       <= set_d;
            acc_min_q   <= acc_min_d;
            acc_max_q   <= acc_max_d;
            acc_sum_q   <= acc_sum_d;
            res_min_q   <= res_min_d;
            res_max_q   <= res_max_d;
            res_sum_q   <= res_sum_d;
            res_avg_q   <= res_avg_d;
            busy_q      <= busy_d;
            res_valid_q <= res_valid_d;
        end
    end

    // Running statistics including the current sample; the first sample seeds them.
    always_comb begin
        first_c   = (cnt_q == '0);
        last_c    = (cnt_q == NW'((32'd1 << n_q) - 32'd1));
        smp_min_c = (first_c || (code_c < acc_min_q)) ? code_c : acc_min_q;
        smp_max_c = (first_c || (code_c > acc_max_q)) ? code_c : acc_max_q;
        smp_sum_c = (first_c ? '0 : acc_sum_q) + SW'(code_c);
    end

    // Next-state and output logic.
    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        cnt_d     = cnt_q;
        set_d     = set_q;
        acc_min_d = acc_min_q;
        acc_max_d = acc_max_q;
        acc_sum_d = acc_sum_q;
        res_min_d = res_min_q;
        res_max_d = res_max_q;
        res_sum_d = res_sum_q;
        res_avg_d = res_avg_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    n_d     = (log2_n > 4'(LOG2_N_MAX)) ? 4'(LOG2_N_MAX) : log2_n;
                    cnt_d   = '0;
                    set_d   = '0;
                    state_d = (SETTLE_LEN == 0) ? ACCUM : SETTLE;
                end
            end
            SETTLE: begin
                if (set_q == SCW'(SETTLE_LEN - 1)) begin
                    state_d = ACCUM;
                end else begin
                    set_d = set_q + SCW'(1);
                end
            end
            ACCUM: begin
                acc_min_d = smp_min_c;
                acc_max_d = smp_max_c;
                acc_sum_d = smp_sum_c;
                cnt_d     = cnt_q + NW'(1);
                if (last_c) begin
                    state_d   = DONE;
                    res_min_d = smp_min_c;
                    res_max_d = smp_max_c;
                    res_sum_d = smp_sum_c;
                    res_avg_d = CW'(smp_sum_c >> n_q);
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d      = (state_d == SETTLE) || (state_d == ACCUM);
        res_valid_d = (state_d == DONE);
    end

    assign busy      = busy_q;
    assign res_valid = res_valid_q;
    assign res_min   = res_min_q;
    assign res_max   = res_max_q;
    assign res_sum   = res_sum_q;
    assign res_avg   = res_avg_q;

endmodule

// File: tb/tb_t_skew_meas_ctrl.sv
// Self-checking bench for t_skew_meas_ctrl (default parameters).
module tb_t_skew_meas_ctrl;

    localparam int CW = 7;
    localparam int SW = 15;
`ifdef SKEW_MEDIAN3_EN
    localparam int SET = 4;
`else
    localparam int SET = 2;
`endif

    logic          clk_b = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [3:0]    log2_n = '0;
    logic [CW-1:0] skew_code = '0;
    logic          busy;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [CW-1:0] res_min, res_max, res_avg;
    logic [SW-1:0] res_sum;

    t_skew_meas_ctrl dut (
        .clk_b     (clk_b),
        .rst_n     (rst_n),
        .start     (start),
        .log2_n    (log2_n),
        .skew_code (skew_code),
        .busy      (busy),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_min   (res_min),
        .res_max   (res_max),
        .res_sum   (res_sum),
        .res_avg   (res_avg)
    );

    always #5 clk_b = ~clk_b;

    typedef struct {
        int ln;
        int code;
        int emin;
        int emax;
        int esum;
        int eavg;
    } vec_t;

    typedef struct {
        int lat;
        int mn;
        int mx;
        int sm;
        int av;
    } exp_t;

    exp_t sb_q[$];
    int   raw[0:511];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int eff_n(input int ln);
        return (ln > 8) ? 8 : ln;
    endfunction

    task automatic fill_const(input int c);
        for (int i = 0; i < 512; i++) raw[i] = c;
    endtask

`ifdef SKEW_MEDIAN3_EN
    function automatic int med3(input int a, input int b, input int c);
        if ((a <= b && b <= c) || (c <= b && b <= a)) return b;
        if ((b <= a && a <= c) || (c <= a && a <= b)) return a;
        return c;
    endfunction
`endif

    // Expected block result from the raw code stream; sample j is the code
    // driven for the j-th edge after the start edge.
    function automatic exp_t model(input int ln);
        exp_t e;
        int   n, v;
        n    = eff_n(ln);
        e.mn = 1 << 30;
        e.mx = -1;
        e.sm = 0;
        for (int j = SET + 1; j <= SET + (1 << n); j++) begin
`ifdef SKEW_MEDIAN3_EN
            v = med3(raw[j-2], raw[j-1], raw[j]);
`else
            v = raw[j];
`endif
            if (v < e.mn) e.mn = v;
            if (v > e.mx) e.mx = v;
            e.sm += v;
        end
        e.av  = e.sm >> n;
        e.lat = SET + (1 << n);
        return e;
    endfunction

    // One full block: start, stream raw[], wait for the result, optionally hold
    // res_ready low for 'hold' cycles with a stray start, then hand it off.
    task automatic run_block(input int ln, input int hold);
        exp_t e;
        int   lat;
        log2_n    = 4'(ln);
        start     = 1'b1;
        skew_code = CW'(raw[0]);
        @(posedge clk_b); #1;
        start = 1'b0;
        lat   = 0;
        for (int i = 1; i <= 400; i++) begin
            skew_code = CW'(raw[i]);
            @(posedge clk_b); #1;
            if (i == 1) check("busy_running", int'(busy), 1);
            if (res_valid) begin
                lat = i;
                break;
            end
        end
        e = sb_q.pop_front();
        check("latency", lat, e.lat);
        check("res_min", int'(res_min), e.mn);
        check("res_max", int'(res_max), e.mx);
        check("res_sum", int'(res_sum), e.sm);
        check("res_avg", int'(res_avg), e.av);
        check("busy_done", int'(busy), 0);
        for (int h = 0; h < hold; h++) begin
            start = (h == 2);
            @(posedge clk_b); #1;
            check("hold_valid", int'(res_valid), 1);
            check("hold_busy", int'(busy), 0);
            check("hold_min", int'(res_min), e.mn);
            check("hold_sum", int'(res_sum), e.sm);
        end
        start     = (hold > 0);
        res_ready = 1'b1;
        @(posedge clk_b); #1;
        start     = 1'b0;
        res_ready = 1'b0;
        check("valid_after_ack", int'(res_valid), 0);
        check("busy_after_ack", int'(busy), 0);
        check("sum_kept_idle", int'(res_sum), e.sm);
    endtask

    vec_t vecs[6];

    initial begin
        exp_t e;

        vecs[0] = '{ln: 2,  code: 20, emin: 20, emax: 20, esum: 80,    eavg: 20};
        vecs[1] = '{ln: 0,  code: 5,  emin: 5,  emax: 5,  esum: 5,     eavg: 5};
        vecs[2] = '{ln: 1,  code: 0,  emin: 0,  emax: 0,  esum: 0,     eavg: 0};
        vecs[3] = '{ln: 3,  code: 64, emin: 64, emax: 64, esum: 512,   eavg: 64};
        vecs[4] = '{ln: 15, code: 64, emin: 64, emax: 64, esum: 16384, eavg: 64};
        vecs[5] = '{ln: 4,  code: 33, emin: 33, emax: 33, esum: 528,   eavg: 33};

        // Reset state.
        repeat (2) @(posedge clk_b);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_valid", int'(res_valid), 0);
        check("rst_min", int'(res_min), 0);
        check("rst_max", int'(res_max), 0);
        check("rst_sum", int'(res_sum), 0);
        check("rst_avg", int'(res_avg), 0);
        rst_n = 1'b1;
        @(posedge clk_b); #1;

        // Constant-code blocks, including the clamp of log2_n=15 to 256 samples.
        for (int t = 0; t < 6; t++) begin
            fill_const(vecs[t].code);
            e.lat = SET + (1 << eff_n(vecs[t].ln));
            e.mn  = vecs[t].emin;
            e.mx  = vecs[t].emax;
            e.sm  = vecs[t].esum;
            e.av  = vecs[t].eavg;
            sb_q.push_back(e);
            run_block(vecs[t].ln, 0);
        end

        // Alternating 10/30 in ACCUM.
        for (int i = 0; i < 512; i++) raw[i] = (((i - (SET + 1)) % 2) == 0) ? 10 : 30;
        sb_q.push_back(model(2));
        run_block(2, 0);

        // Ramp with a truncated mean.
        for (int i = 0; i < 512; i++) raw[i] = (i * 3) % 65;
        sb_q.push_back(model(3));
        run_block(3, 0);

        // Single-sample spike in the window.
        fill_const(10);
        raw[SET + 3] = 60;
        e = model(2);
`ifdef SKEW_MEDIAN3_EN
        check("spike_model_max", e.mx, 10);
`else
        check("spike_model_max", e.mx, 60);
`endif
        sb_q.push_back(e);
        run_block(2, 0);

        // Back-pressure in DONE with a stray start.
        fill_const(17);
        sb_q.push_back(model(1));
        run_block(1, 5);

        // Reset in the middle of ACCUM aborts the block.
        fill_const(20);
        log2_n    = 4'd2;
        skew_code = CW'(20);
        start     = 1'b1;
        @(posedge clk_b); #1;
        start = 1'b0;
        repeat (SET + 2) @(posedge clk_b);
        #1;
        check("mid_accum_busy", int'(busy), 1);
        rst_n = 1'b0;
        @(posedge clk_b); #1;
        rst_n = 1'b1;
        check("abort_busy", int'(busy), 0);
        check("abort_valid", int'(res_valid), 0);
        check("abort_min", int'(res_min), 0);
        check("abort_max", int'(res_max), 0);
        check("abort_sum", int'(res_sum), 0);
        check("abort_avg", int'(res_avg), 0);

        // Clean block after the abort.
        for (int i = 0; i < 512; i++) raw[i] = 40 + (i % 5);
        sb_q.push_back(model(2));
        run_block(2, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
